i2c_reg_slave: RTL and testbench
================================

# i2c_reg_slave

I2C write-only target (responder) that decodes the 3-byte register-write frames issued by the team's I2C master: device address + W, {register[6:0], data[8]}, data[7:0]. It oversamples SCL/SDA on the system clock, acknowledges each byte, and emits a one-cycle register-write strobe with a 7-bit address and 9-bit data. It sits behind the board I2C pins and lets the FPGA act as a codec-style register target, or model one in loopback tests against the master.

## Interface
- DEVICE_ID, 7'h1A: 7-bit address this target answers to.
- clk  input  1  system clock; must be at least 16x the SCL frequency.
- reset  input  1  asynchronous, active-high.
- scl  input  1  I2C clock; no clock stretching.
- sda  inout  1  I2C data, open-drain: driven 1'b0 when acking, otherwise 1'bz.
- wr_en  output  1  one-cycle pulse when a complete, acknowledged write frame has been received.
- reg_addr  output  7  register address of the last frame; held until the next wr_en.
- reg_data  output  9  {byte2[0], byte3[7:0]} of the last frame; held until the next wr_en.
- busy  output  1  high from an addressed START until the STOP or abort.
- err  output  1  sticky protocol error flag; cleared on the next START.
- stt  output  4  current state encoding, for debug.

## Operation
- Input conditioning:
  - scl and sda each pass through a 2-flop synchronizer plus one history flop.
  - Edges are detected on the synchronized values.
- Bus conditions:
  - START: synchronized sda falls while scl is high.
  - STOP: synchronized sda rises while scl is high.
  - Both are recognized in every state, including during ACK.
- Bit handling:
  - Data is sampled on scl rising edges, MSB first.
  - A bit counter runs 7 down to 0.
  - A shift register assembles each byte.
- States:
  - IDLE (0): waits for START, then goes to ADDR with the counter at 7.
  - ADDR (1): 8 bits are shifted in. If the address bits [7:1] equal DEVICE_ID and the R/W bit [0] is 0, go to ACK1 and set busy=1. Otherwise go to IGNORE; this is not an error.
  - ACK1 (2): on the scl falling edge after bit 0, drive sda low. Hold it low through the next scl high phase. Release on the following scl falling edge and go to REG.
  - REG (3): 8 bits are shifted in. Latch byte2 into a holding register, then go to ACK2.
  - ACK2 (4): same ACK behaviour as ACK1, then go to DATA.
  - DATA (5): 8 bits are shifted in. Update reg_addr=byte2[7:1] and reg_data={byte2[0],byte3}, pulse wr_en, then go to ACK3.
  - ACK3 (6): same ACK behaviour, then go to DONE.
  - DONE (7): any further byte gets no ACK (sda stays z); set err=1 at its 8th bit and stay in DONE. STOP goes to IDLE.
  - IGNORE (8): sda stays z. Only START or STOP leave this state.
- Aborts and restarts:
  - STOP in ADDR, ACK1, REG, ACK2 or DATA: abort, set err=1, no wr_en, go to IDLE.
  - Repeated START in any state: go to ADDR, set err=0. If the current frame is incomplete (not DONE or IGNORE), set err=1 instead.
  - sda is released within 1 cycle of any START, STOP or abort.
- busy: set on entry to ACK1, cleared on entry to IDLE or IGNORE.

## Timing
- Reset values: wr_en=0, reg_addr=0, reg_data=0, busy=0, err=0, stt=0, sda=z. All internal state returns to IDLE.
- Reset mid-frame releases sda asynchronously. No wr_en is produced.
- Pin-to-detect latency: 3 clk cycles from a pin edge to its detection.
- wr_en is asserted in the cycle after the detected scl rising edge of the data byte's bit 0. It is high for exactly 1 cycle.
- reg_addr and reg_data change in the same cycle wr_en rises.
- ACK drive begins 1 cycle after the detected scl falling edge of bit 0. It ends 1 cycle after the detected scl falling edge of the ACK clock.
- A START and an scl edge detected in the same cycle: START wins.

## Test plan
- Write 0x34, 0x0F, 0xA5 (ID 0x1A, reg 0x07, d8=1) at 100 kHz with clk 50 MHz -> ACK on all 3 bytes; single wr_en; reg_addr=0x07, reg_data=0x1A5; err=0; busy falls at STOP.
- Address 0x36 (ID 0x1B) -> no ACK; stays in IGNORE; no wr_en; err=0; sda stays z for the whole frame.
- Address 0x35 (read bit set) -> no ACK, no wr_en.
- STOP issued after byte2's ACK -> err=1, no wr_en, state IDLE; a following valid frame clears err and writes normally.
- 4-byte frame 0x34, 0x02, 0x55, 0xFF -> wr_en for reg 0x01, data 0x055; 4th byte NACKed; err=1.
- Assert reset while sda is held low during ACK1 -> sda z within the same cycle; all outputs at reset values; no wr_en.

Source files
------------

// File: rtl/i2c_reg_slave.sv
// i2c_reg_slave: write-only I2C target that decodes 3-byte register-write
// frames (addr+W, {reg[6:0], d8}, d[7:0]), ACKs each byte and emits a
// one-cycle register-write strobe. SCL/SDA are oversampled on clk.
module i2c_reg_slave #(
  parameter logic [6:0] DEVICE_ID = 7'h1A
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  output logic       wr_en,
  output logic [6:0] reg_addr,
  output logic [8:0] reg_data,
  output logic       busy,
  output logic       err,
  output logic [3:0] stt
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_ADDR   = 4'd1;
  localparam logic [3:0] S_ACK1   = 4'd2;
  localparam logic [3:0] S_REG    = 4'd3;
  localparam logic [3:0] S_ACK2   = 4'd4;
  localparam logic [3:0] S_DATA   = 4'd5;
  localparam logic [3:0] S_ACK3   = 4'd6;
  localparam logic [3:0] S_DONE   = 4'd7;
  localparam logic [3:0] S_IGNORE = 4'd8;

  // Synchronizer and history flops
  logic scl_s1, scl_s2, scl_h;
  logic sda_s1, sda_s2, sda_h;

  logic [3:0] state_reg;
  logic [2:0] bit_cnt_reg;
  logic [6:0] shift_reg;
  logic [7:0] byte2_reg;
  logic       sda_oe_reg;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] byte_next;

  // Open-drain pin: only ever pull low
  assign sda = sda_oe_reg ? 1'b0 : 1'bz;
  assign stt = state_reg;

  // Bring the asynchronous bus lines into the clk domain; idle bus is high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_h  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_h  <= 1'b1;
    end else begin
      scl_s1 <= scl;
      scl_s2 <= scl_s1;
      scl_h  <= scl_s2;
      sda_s1 <= sda;
      sda_s2 <= sda_s1;
      sda_h  <= sda_s2;
    end
  end

  // Edge and bus-condition decode on the synchronized values
  always_comb begin
    scl_rise  = scl_s2 & ~scl_h;
    scl_fall  = ~scl_s2 & scl_h;
    start_det = scl_s2 & scl_h & sda_h & ~sda_s2;
    stop_det  = scl_s2 & scl_h & ~sda_h & sda_s2;
    byte_next = {shift_reg, sda_s2};
  end

  // Frame decoder: START/STOP take priority over any bit or ACK activity
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      bit_cnt_reg <= 3'd7;
      shift_reg   <= 7'd0;
      byte2_reg   <= 8'd0;
      sda_oe_reg  <= 1'b0;
      wr_en       <= 1'b0;
      reg_addr    <= 7'd0;
      reg_data    <= 9'd0;
      busy        <= 1'b0;
      err         <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (start_det) begin
        // A restart in the middle of a frame leaves that frame unfinished
        err         <= state_reg inside {S_ADDR, S_ACK1, S_REG, S_ACK2, S_DATA, S_ACK3};
        state_reg   <= S_ADDR;
        bit_cnt_reg <= 3'd7;
        sda_oe_reg  <= 1'b0;
      end else if (stop_det) begin
        if (state_reg inside {S_ADDR, S_ACK1, S_REG, S_ACK2, S_DATA})
          err <= 1'b1;
        state_reg  <= S_IDLE;
        sda_oe_reg <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state_reg)
          S_ADDR, S_REG, S_DATA, S_DONE: begin
            if (scl_rise) begin
              shift_reg   <= byte_next[6:0];
              bit_cnt_reg <= bit_cnt_reg - 3'd1;
              if (bit_cnt_reg == 3'd0) begin
                case (state_reg)
                  S_ADDR: begin
                    if (byte_next == {DEVICE_ID, 1'b0}) begin
                      state_reg <= S_ACK1;
                      busy      <= 1'b1;
                    end else begin
                      state_reg <= S_IGNORE;
                      busy      <= 1'b0;
                    end
                  end
                  S_REG: begin
                    byte2_reg <= byte_next;
                    state_reg <= S_ACK2;
                  end
                  S_DATA: begin
                    reg_addr  <= byte2_reg[7:1];
                    reg_data  <= {byte2_reg[0], byte_next};
                    wr_en     <= 1'b1;
                    state_reg <= S_ACK3;
                  end
                  default: err <= 1'b1;  // extra byte after a full frame
                endcase
              end
            end
          end
          S_ACK1, S_ACK2, S_ACK3: begin
            // First fall (end of bit 0) grabs the line, second fall releases it
            if (scl_fall) begin
              if (!sda_oe_reg) begin
                sda_oe_reg <= 1'b1;
              end else begin
                sda_oe_reg  <= 1'b0;
                bit_cnt_reg <= 3'd7;
                case (state_reg)
                  S_ACK1:  state_reg <= S_REG;
                  S_ACK2:  state_reg <= S_DATA;
                  default: state_reg <= S_DONE;
                endcase
              end
            end
          end
          default: ;  // IDLE and IGNORE only react to START/STOP
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_slave.sv
// tb_i2c_reg_slave: bit-banged I2C master driving directed and random frames;
// expectations come from a frame-level model of the target's rules.
module tb_i2c_reg_slave;

  localparam logic [6:0] ID = 7'h1A;
  localparam int Q = 8;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       reset;
  logic       scl;
  logic       master_low;
  wire        sda_w;
  logic       wr_en;
  logic [6:0] reg_addr;
  logic [8:0] reg_data;
  logic       busy;
  logic       err;
  logic [3:0] stt;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int dut_low_cnt = 0;

  logic [6:0] exp_addr = 7'd0;
  logic [8:0] exp_data = 9'd0;
  bit         prev_incomplete = 1'b0;

  assign sda_w = master_low ? 1'b0 : 1'bz;
  pullup (sda_w);

  i2c_reg_slave #(.DEVICE_ID(ID)) dut (
    .clk(clk), .reset(reset), .scl(scl), .sda(sda_w),
    .wr_en(wr_en), .reg_addr(reg_addr), .reg_data(reg_data),
    .busy(busy), .err(err), .stt(stt)
  );

  always #10 clk = ~clk;

  // Count write strobes (a stretched strobe shows up as an extra count)
  always @(negedge clk) if (wr_en) wr_cnt <= wr_cnt + 1;

  // Count cycles where the target pulls the line low on its own
  always begin
    @(posedge clk);
    #1;
    if (!master_low && sda_w === 1'b0) dut_low_cnt = dut_low_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_c();
    master_low = 1'b1; wq(Q);
    scl = 1'b0; wq(Q);
  endtask

  task automatic rstart_c();
    master_low = 1'b0; wq(Q);
    scl = 1'b1; wq(Q);
    master_low = 1'b1; wq(Q);
    scl = 1'b0; wq(Q);
  endtask

  task automatic stop_c();
    master_low = 1'b1; wq(Q);
    scl = 1'b1; wq(Q);
    master_low = 1'b0; wq(2 * Q);
  endtask

  task automatic send_bit(input bit b);
    master_low = !b; wq(Q);
    scl = 1'b1; wq(2 * Q);
    scl = 1'b0; wq(Q);
  endtask

  task automatic read_ack(output bit a);
    master_low = 1'b0; wq(Q);
    scl = 1'b1; wq(Q);
    a = (sda_w === 1'b0);
    wq(Q);
    scl = 1'b0; wq(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output bit a);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    read_ack(a);
  endtask

  // Drive one frame (bytes packed MSB-first) and check it against the model
  task automatic do_frame(input string name, input logic [31:0] bytes, input int nb,
                          input bit rep, input bit end_stop);
    logic [7:0] bt;
    bit ack, addressed, exp_err, exp_wr;
    int wr0;
    addressed = (bytes[31:24] == {ID, 1'b0});
    exp_wr    = addressed && nb >= 3;
    exp_err   = rep && prev_incomplete;
    wr0 = wr_cnt;
    dut_low_cnt = 0;
    if (rep) rstart_c(); else start_c();
    for (int i = 0; i < nb; i++) begin
      bt = bytes[31 - 8 * i -: 8];
      send_byte(bt, ack);
      chk($sformatf("%s ack%0d", name, i), {31'd0, ack}, {31'd0, addressed && i < 3});
      if (i == 0) chk($sformatf("%s busy_mid", name), {31'd0, busy}, {31'd0, addressed});
    end
    if (exp_wr) begin
      exp_addr = bytes[23:17];
      exp_data = {bytes[16], bytes[15:8]};
    end
    if (addressed && nb >= 4) exp_err = 1'b1;
    if (end_stop) begin
      stop_c();
      if (addressed && nb < 3) exp_err = 1'b1;
      prev_incomplete = 1'b0;
      chk($sformatf("%s stt", name), {28'd0, stt}, 32'd0);
      chk($sformatf("%s busy_end", name), {31'd0, busy}, 32'd0);
    end else begin
      prev_incomplete = addressed && nb < 3;
      chk($sformatf("%s busy_open", name), {31'd0, busy}, {31'd0, addressed});
    end
    chk($sformatf("%s wr_cnt", name), wr_cnt - wr0, {31'd0, exp_wr});
    chk($sformatf("%s reg_addr", name), {25'd0, reg_addr}, {25'd0, exp_addr});
    chk($sformatf("%s reg_data", name), {23'd0, reg_data}, {23'd0, exp_data});
    chk($sformatf("%s err", name), {31'd0, err}, {31'd0, exp_err});
    if (!addressed) chk($sformatf("%s sda_quiet", name), dut_low_cnt, 32'd0);
    $display("frame %s b=%08h nb=%0d wr=%0d addr=%02h data=%03h err=%0d",
             name, bytes, nb, wr_cnt - wr0, reg_addr, reg_data, err);
  endtask

  initial begin
    logic [7:0] b0;
    int sel, nb, wr0;

    reset = 1'b1; scl = 1'b1; master_low = 1'b0;
    wq(3);
    chk("rst wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst reg_addr", {25'd0, reg_addr}, 32'd0);
    chk("rst reg_data", {23'd0, reg_data}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst err", {31'd0, err}, 32'd0);
    chk("rst stt", {28'd0, stt}, 32'd0);
    chk("rst sda", {31'd0, sda_w}, 32'd1);
    reset = 1'b0;
    wq(4);

    do_frame("valid",    32'h340FA500, 3, 1'b0, 1'b1);
    do_frame("wrong_id", 32'h36123400, 3, 1'b0, 1'b1);
    do_frame("read_bit", 32'h35123400, 3, 1'b0, 1'b1);
    do_frame("abort",    32'h34123400, 2, 1'b0, 1'b1);
    do_frame("recover",  32'h34441100, 3, 1'b0, 1'b1);
    do_frame("four_b",   32'h340255FF, 4, 1'b0, 1'b1);
    do_frame("open",     32'h34200000, 2, 1'b0, 1'b0);
    do_frame("restart",  32'h340ABC00, 3, 1'b1, 1'b1);
    do_frame("clear",    32'h34FE0100, 3, 1'b0, 1'b1);

    // Reset while the target is holding the ACK low
    wr0 = wr_cnt;
    start_c();
    for (int i = 7; i >= 0; i--) send_bit(b0_const(i));
    master_low = 1'b0; wq(Q);
    scl = 1'b1; wq(Q);
    chk("rst_ack pre sda", {31'd0, sda_w}, 32'd0);
    chk("rst_ack pre stt", {28'd0, stt}, 32'd2);
    #3 reset = 1'b1;
    #1;
    chk("rst_ack sda", {31'd0, sda_w}, 32'd1);
    chk("rst_ack stt", {28'd0, stt}, 32'd0);
    chk("rst_ack busy", {31'd0, busy}, 32'd0);
    chk("rst_ack reg_addr", {25'd0, reg_addr}, 32'd0);
    chk("rst_ack reg_data", {23'd0, reg_data}, 32'd0);
    chk("rst_ack wr", wr_cnt - wr0, 32'd0);
    $display("reset during ACK1: sda=%0b stt=%0d", sda_w, stt);
    exp_addr = 7'd0; exp_data = 9'd0; prev_incomplete = 1'b0;
    wq(2);
    reset = 1'b0;
    wq(4);

    for (int n = 0; n < 30; n++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0, 1, 2: b0 = 8'h34;
        3:       b0 = 8'h35;
        4:       b0 = 8'h36;
        default: b0 = 8'($urandom);
      endcase
      nb = $urandom_range(1, 4);
      do_frame($sformatf("rnd%0d", n), {b0, 24'($urandom)}, nb, 1'b0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic bit b0_const(input int i);
    logic [7:0] v;
    v = {ID, 1'b0};
    return v[i];
  endfunction

endmodule
